boxcar_notch_filter: RTL and testbench



---
 rtl/filter_pkg.sv | 25 ++
 rtl/boxcar_lane.sv | 67 ++++++
 rtl/boxcar_notch_filter.sv | 124 ++++++++++++
 tb/tb_boxcar_notch_filter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/filter_pkg.sv
// Shared types and helpers for the boxcar notch filter and its lanes.
package filter_pkg;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_RUN    = 2'd1,
        ST_RETUNE = 2'd2
    } state_t;

    function automatic int acc_width(input int data_width, input int max_window);
        return data_width + $clog2(max_window) + 1;
    endfunction

    function automatic int clamp_window(input int req, input int max_window);
        if (req < 1) return 1;
        if (req > max_window) return max_window;
        return req;
    endfunction

    // Rounded fixed-point 1/w; w is always a clamped window, never zero.
    function automatic int reciprocal(input int w, input int shift);
        return ((1 << shift) + w / 2) / w;
    endfunction

endpackage

// File: rtl/boxcar_lane.sv
// One filter lane: circular sample buffer, running sum, reciprocal scale,
// round-half-up and saturation back to the sample width.
module boxcar_lane
    import filter_pkg::*;
#(
    parameter int  DATA_WIDTH  = 12,
    parameter int  MAX_WINDOW  = 32,
    parameter int  RECIP_SHIFT = 16,
    localparam int PW          = $clog2(MAX_WINDOW),
    localparam int RW          = RECIP_SHIFT + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  accept,
    input  logic                  fill,
    input  logic [PW-1:0]         w_m1,
    input  logic [RW-1:0]         recip,
    input  logic [DATA_WIDTH-1:0] sample,
    output logic [DATA_WIDTH-1:0] scaled
);
    localparam int AW  = acc_width(DATA_WIDTH, MAX_WINDOW);
    localparam int PRW = AW + RW + 1;
    localparam logic signed [PRW-1:0] HALF   = PRW'(longint'(1) << (RECIP_SHIFT - 1));
    localparam logic signed [PRW-1:0] SAT_HI = PRW'((longint'(1) << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [PRW-1:0] SAT_LO = PRW'(-(longint'(1) << (DATA_WIDTH - 1)));

    logic [DATA_WIDTH-1:0]        buf_mem [MAX_WINDOW];
    logic [PW-1:0]                wr_ptr;
    logic [PW-1:0]                rd_ptr;
    logic signed [AW-1:0]         acc;
    logic signed [DATA_WIDTH-1:0] s_new;
    logic signed [DATA_WIDTH-1:0] s_old;
    logic signed [PRW-1:0]        prod;
    logic signed [PRW-1:0]        rounded;

    // (wr_ptr - W) mod MAX_WINDOW with W = w_m1 + 1, kept inside PW bits
    assign rd_ptr = (wr_ptr > w_m1) ? wr_ptr - w_m1 - 1'b1
                                    : wr_ptr + (PW'(MAX_WINDOW - 1) - w_m1);
    assign s_new  = sample;
    assign s_old  = fill ? '0 : buf_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < MAX_WINDOW; i++) buf_mem[i] <= '0;
        end else if (clear) begin
            acc    <= '0;
            wr_ptr <= '0;
        end else if (accept) begin
            buf_mem[wr_ptr] <= sample;
            acc    <= acc + AW'(s_new) - AW'(s_old);
            wr_ptr <= (wr_ptr == PW'(MAX_WINDOW - 1)) ? '0 : wr_ptr + 1'b1;
        end
    end

    assign prod    = PRW'(acc) * PRW'($signed({1'b0, recip}));
    assign rounded = (prod + HALF) >>> RECIP_SHIFT;

    always_comb begin
        scaled = rounded[DATA_WIDTH-1:0];
        if (rounded > SAT_HI)      scaled = SAT_HI[DATA_WIDTH-1:0];
        else if (rounded < SAT_LO) scaled = SAT_LO[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/boxcar_notch_filter.sv
// Multi-lane boxcar notch with run-time window, fill tracking, retune on
// window change and a bypass path matched to the two-stage filter latency.
//   state     | meaning
//   ST_FILL   | window not yet full; accepted samples counted, no filter output
//   ST_RUN    | window full; every accepted sample yields one output
//   ST_RETUNE | first cycle after a window change; lanes freshly cleared
module boxcar_notch_filter
    import filter_pkg::*;
#(
    parameter int  DATA_WIDTH     = 12,
    parameter int  CHANNELS       = 1,
    parameter int  MAX_WINDOW     = 32,
    parameter int  DEFAULT_WINDOW = 21,
    parameter int  RECIP_SHIFT    = 16,
    localparam int WL             = $clog2(MAX_WINDOW + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
    input  logic [WL-1:0]                  win_len,
    input  logic                           bypass,
    output logic                           out_valid,
    output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
    output logic                           filling
);
    localparam int PW    = $clog2(MAX_WINDOW);
    localparam int RW    = RECIP_SHIFT + 1;
    localparam int W_RST = clamp_window(DEFAULT_WINDOW, MAX_WINDOW);
    localparam int R_RST = reciprocal(W_RST, RECIP_SHIFT);

    state_t                         state;
    logic [PW-1:0]                  w_m1_reg;
    logic [PW-1:0]                  w_m1_req;
    logic [PW-1:0]                  fill_cnt;
    logic [RW-1:0]                  recip_reg;
    logic [RW-1:0]                  recip_req;
    logic                           retune_det;
    logic                           accept;
    logic                           fill_done;
    logic                           v1;
    logic                           byp_valid;
    logic [CHANNELS*DATA_WIDTH-1:0] byp_data;
    logic [CHANNELS*DATA_WIDTH-1:0] lane_out;

    // Window held as W-1 so it fits the pointer width even at W = MAX_WINDOW
    assign w_m1_req   = PW'(clamp_window(int'(win_len), MAX_WINDOW) - 1);
    assign recip_req  = RW'(reciprocal(clamp_window(int'(win_len), MAX_WINDOW), RECIP_SHIFT));
    assign retune_det = (w_m1_req != w_m1_reg);
    assign accept     = in_valid && !retune_det;
    assign fill_done  = (fill_cnt == w_m1_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FILL;
            w_m1_reg  <= PW'(W_RST - 1);
            recip_reg <= RW'(R_RST);
            fill_cnt  <= '0;
            v1        <= 1'b0;
            filling   <= 1'b1;
        end else if (retune_det) begin
            state     <= ST_RETUNE;
            w_m1_reg  <= w_m1_req;
            recip_reg <= recip_req;
            fill_cnt  <= '0;
            v1        <= 1'b0;
            filling   <= 1'b1;
        end else begin
            case (state)
                ST_RUN: v1 <= in_valid;
                default: begin
                    v1 <= in_valid && fill_done;
                    if (in_valid && fill_done) begin
                        state    <= ST_RUN;
                        fill_cnt <= '0;
                        filling  <= 1'b0;
                    end else begin
                        state <= ST_FILL;
                        if (in_valid) fill_cnt <= fill_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        boxcar_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .MAX_WINDOW (MAX_WINDOW),
            .RECIP_SHIFT(RECIP_SHIFT)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .clear (retune_det),
            .accept(accept),
            .fill  (state != ST_RUN),
            .w_m1  (w_m1_reg),
            .recip (recip_reg),
            .sample(in_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .scaled(lane_out[c*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // Stage 2: bypass taps one register behind the input to match filter latency
    always_ff @(posedge clk) begin
        if (rst) begin
            byp_data  <= '0;
            byp_valid <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            byp_data  <= in_data;
            byp_valid <= in_valid;
            if (bypass) begin
                out_valid <= byp_valid;
                out_data  <= byp_data;
            end else begin
                out_valid <= v1;
                if (v1) out_data <= lane_out;
            end
        end
    end

endmodule

// File: tb/tb_boxcar_notch_filter.sv
// Directed bench for boxcar_notch_filter with two lanes and default window settings.
module tb_boxcar_notch_filter;
    import filter_pkg::*;

    localparam int DW = 12;
    localparam int CH = 2;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic [CH*DW-1:0] in_data;
    logic [5:0]      win_len;
    logic            bypass;
    logic            out_valid;
    logic [CH*DW-1:0] out_data;
    logic            filling;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    boxcar_notch_filter #(
        .DATA_WIDTH    (DW),
        .CHANNELS      (CH),
        .MAX_WINDOW    (32),
        .DEFAULT_WINDOW(21),
        .RECIP_SHIFT   (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .win_len  (win_len),
        .bypass   (bypass),
        .out_valid(out_valid),
        .out_data (out_data),
        .filling  (filling)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int a, input int b);
        in_valid = v;
        in_data  = {b[DW-1:0], a[DW-1:0]};
    endtask

    function automatic int lane(input int c);
        logic signed [DW-1:0] s;
        s = out_data[c*DW +: DW];
        return int'(s);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; win_len = 6'd21; bypass = 1'b0;
        tick(); tick();
        check("rst_valid", int'(out_valid), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_filling", int'(filling), 1);
        rst = 1'b0;

        // W=21 DC fill: 1000 on lane 0, -300 on lane 1
        for (int k = 1; k <= 21; k++) begin
            drive(1'b1, 1000, -300); tick();
            if (k == 20) check("dc_fill20", int'(filling), 1);
            if (k == 21) begin
                check("dc_fill21", int'(filling), 0);
                check("dc_no_early", int'(out_valid), 0);
            end
        end
        for (int k = 22; k <= 24; k++) begin
            drive(1'b1, 1000, -300); tick();
            check("dc_valid", int'(out_valid), 1);
            check("dc_lane0", lane(0), 1000);
            check("dc_lane1", lane(1), -300);
        end

        // Alternating +/-500: one unpaired sample of 21 -> +/-24
        for (int k = 1; k <= 23; k++) begin
            drive(1'b1, (k % 2 == 1) ? 500 : -500, (k % 2 == 1) ? -500 : 500); tick();
            if (k == 22) begin
                check("alt_pos_l0", lane(0), 24);
                check("alt_pos_l1", lane(1), -24);
            end
            if (k == 23) begin
                check("alt_neg_l0", lane(0), -24);
                check("alt_neg_l1", lane(1), 24);
            end
        end

        // Retune 21 -> 10: sample on detect cycle (2000) must be dropped
        win_len = 6'd10;
        drive(1'b1, 2000, 2000); tick();
        check("retune_filling", int'(filling), 1);
        for (int k = 1; k <= 11; k++) begin
            drive(1'b1, 100 * k, -100 * k); tick();
            if (k == 1) check("retune_gap", int'(out_valid), 0);
            if (k == 9) check("retune_fill9", int'(filling), 1);
            if (k == 10) begin
                check("retune_fill10", int'(filling), 0);
                check("retune_no_early", int'(out_valid), 0);
            end
            if (k == 11) begin
                check("retune_valid", int'(out_valid), 1);
                check("retune_mean_l0", lane(0), 550);
                check("retune_mean_l1", lane(1), -550);
            end
        end

        // win_len=0 -> W=1, gapped input, full-scale corners
        win_len = 6'd0;
        drive(1'b1, 1500, 1500); tick();
        drive(1'b1, 2047, 7); tick();
        drive(1'b0, 0, 0); tick();
        check("w1_valid", int'(out_valid), 1);
        check("w1_max_l0", lane(0), 2047);
        check("w1_l1", lane(1), 7);
        drive(1'b0, 0, 0); tick();
        check("w1_gap", int'(out_valid), 0);
        drive(1'b1, -2048, -1); tick();
        drive(1'b0, 0, 0); tick();
        check("w1_valid2", int'(out_valid), 1);
        check("w1_min_l0", lane(0), -2048);
        check("w1_neg1_l1", lane(1), -1);
        drive(1'b0, 0, 0); tick();
        check("w1_gap2", int'(out_valid), 0);
        check("w1_hold_l0", lane(0), -2048);

        // win_len=40 -> W=32 with full-scale constants
        win_len = 6'd40;
        drive(1'b1, 0, 0); tick();
        for (int k = 1; k <= 33; k++) begin
            drive(1'b1, 2047, -2048); tick();
            if (k == 31) check("w32_fill31", int'(filling), 1);
            if (k == 32) check("w32_fill32", int'(filling), 0);
            if (k == 33) begin
                check("w32_valid", int'(out_valid), 1);
                check("w32_max_l0", lane(0), 2047);
                check("w32_min_l1", lane(1), -2048);
            end
        end

        // Bypass ramp: output equals input driven two cycles earlier
        bypass = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            drive(k != 4, 10 * k, -k); tick();
            if (k >= 3) begin
                check("byp_valid", int'(out_valid), (k - 1 != 4) ? 1 : 0);
                check("byp_l0", lane(0), 10 * (k - 1));
                check("byp_l1", lane(1), -(k - 1));
            end
        end

        // Reset pulse mid-run
        check("pre_rst_filling", int'(filling), 0);
        rst = 1'b1;
        drive(1'b1, 10, 10); tick();
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_data", int'(out_data), 0);
        check("midrst_filling", int'(filling), 1);
        rst = 1'b0; bypass = 1'b0; in_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
